// File: rtl/bcd_counter_pkg.sv
// Shared types and constants for the BCD event counter.
package bcd_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    MANUAL    = 2'b00,
    AUTO_HOLD = 2'b01,
    AUTO_RUN  = 2'b10
  } state_e;

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit (0..9) with carry-in increment and synchronous clear.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);

  logic [BCD_W-1:0] value_next;

  always_comb begin
    value_next = value;
    if (clear) begin
      value_next = '0;
    end else if (inc) begin
      value_next = (value == BCD_MAX) ? '0 : value + BCD_W'(1);
    end
  end

  // Combinational so a carry ripples through all digits in one cycle.
  assign carry_out = inc & (value == BCD_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else begin
      value <= value_next;
    end
  end

endmodule

// File: rtl/bcd_event_counter.sv
// Multi-digit BCD event counter: manual trigger counting or auto ticking with
// trigger as start/stop. Define BCD_SATURATE_EN to saturate at all-9s instead of wrapping.
module bcd_event_counter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  trigger,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  running,
  output state_e                state_dbg
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  state_e           state, state_next;
  logic             trigger_q;
  logic             rise;
  logic             tick;
  logic             mode_steady;
  logic             inc_req;
  logic             inc;
  logic             wrap_next;
  logic [DIV_W-1:0] div, div_next;
  logic [DIGITS:0]  carry;

  // Trigger handshake: a single-cycle event is a low-to-high level change.
  assign rise = trigger & ~trigger_q;
  // High when this cycle involves no mode transition, so events are not consumed.
  assign mode_steady = (state == MANUAL) ? ~mode : mode;
  assign tick = (state == AUTO_RUN) && (div == DIV_LAST);
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    if (!clear) begin
      if (!mode) begin
        state_next = MANUAL;
      end else begin
        case (state)
          MANUAL:    state_next = AUTO_HOLD;
          AUTO_HOLD: if (rise) state_next = AUTO_RUN;
          AUTO_RUN:  if (rise) state_next = AUTO_HOLD;
          default:   state_next = MANUAL;
        endcase
      end
    end
  end

  always_comb begin
    div_next = div;
    if (clear || state == MANUAL) begin
      div_next = '0;
    end else if (state == AUTO_RUN && mode) begin
      div_next = tick ? '0 : div + DIV_W'(1);
    end
  end

  assign inc_req = !clear && mode_steady && ((state == MANUAL && rise) || tick);

`ifdef BCD_SATURATE_EN
  logic all_nines;
  logic almost_nines;

  always_comb begin
    all_nines    = 1'b1;
    almost_nines = (count[BCD_W-1:0] == BCD_MAX - BCD_W'(1));
    for (int i = 0; i < DIGITS; i++) begin
      if (count[i*BCD_W +: BCD_W] != BCD_MAX) all_nines = 1'b0;
      if (i > 0 && count[i*BCD_W +: BCD_W] != BCD_MAX) almost_nines = 1'b0;
    end
  end

  assign inc       = inc_req && !all_nines;
  assign wrap_next = !clear && (all_nines || (inc && almost_nines));
`else
  assign inc       = inc_req;
  assign wrap_next = carry[DIGITS];
`endif

  assign carry[0] = inc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clock     (clock),
      .reset     (reset),
      .clear     (clear),
      .inc       (carry[g]),
      .value     (count[g*BCD_W +: BCD_W]),
      .carry_out (carry[g+1])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= MANUAL;
      trigger_q <= 1'b1;
      div       <= '0;
      wrap      <= 1'b0;
      running   <= 1'b0;
    end else begin
      state     <= state_next;
      trigger_q <= trigger;
      div       <= div_next;
      wrap      <= wrap_next;
      running   <= (state_next == AUTO_RUN);
    end
  end

endmodule
